// File: rtl/ikaopll_bus_writer_if.sv
// Request handshake plus the IKAOPLL-facing CPU bus driven by the write sequencer.
interface ikaopll_bus_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_a0;
  logic [7:0] req_data;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] d;
  logic       busy;
  logic       guard_active;
  logic       phim_tick;

  modport master (
    output req_valid, req_a0, req_data,
    input  req_ready, cs_n, wr_n, a0, d, busy, guard_active, phim_tick
  );

  modport slave (
    input  req_valid, req_a0, req_data,
    output req_ready, cs_n, wr_n, a0, d, busy, guard_active, phim_tick
  );
endinterface

// File: rtl/ikaopll_bus_writer.sv
// phiM-aligned write sequencer for IKAOPLL: setup/strobe/hold bus timing plus
// the YM2413 minimum gap after address and data writes.
module ikaopll_bus_writer #(
  parameter int PHIM_DIV      = 4,
  parameter int WR_TICKS      = 2,
  parameter int MIN_WAIT_ADDR = 12,
  parameter int MIN_WAIT_DATA = 84
) (
  input logic                 i_XIN_EMUCLK,
  input logic                 i_IC_n,
  ikaopll_bus_writer_if.slave bus
);

  localparam int DIV_W    = (PHIM_DIV > 1) ? $clog2(PHIM_DIV) : 1;
  localparam int STB_W    = (WR_TICKS > 1) ? $clog2(WR_TICKS) : 1;
  localparam int MAX_WAIT = (MIN_WAIT_ADDR > MIN_WAIT_DATA) ? MIN_WAIT_ADDR : MIN_WAIT_DATA;
  localparam int GRD_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PHIM_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(WR_TICKS - 1);
  localparam logic [GRD_W-1:0] GUARD_ADR = GRD_W'(MIN_WAIT_ADDR);
  localparam logic [GRD_W-1:0] GUARD_DAT = GRD_W'(MIN_WAIT_DATA);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [GRD_W-1:0] guard_q, guard_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic             lat_a0_q, lat_a0_d;
  logic [7:0]       lat_data_q, lat_data_d;
  logic             cs_n_q, cs_n_d;
  logic             wr_n_q, wr_n_d;
  logic             a0_q, a0_d;
  logic [7:0]       d_q, d_d;

  // tick_q is high during the last divider cycle, so the edge that ends it is the tick edge
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_d == DIV_LAST);
  end

  always_comb begin
    state_d    = state_q;
    guard_d    = guard_q;
    stb_d      = stb_q;
    lat_a0_d   = lat_a0_q;
    lat_data_d = lat_data_q;
    cs_n_d     = cs_n_q;
    wr_n_d     = wr_n_q;
    a0_d       = a0_q;
    d_d        = d_q;

    if (tick_q && (guard_q != '0))
      guard_d = guard_q - GRD_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          lat_a0_d   = bus.req_a0;
          lat_data_d = bus.req_data;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // guard==1 is about to expire on this tick, so the gap is exactly the guard length
        if (tick_q && (guard_q <= GRD_W'(1))) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          wr_n_d  = 1'b1;
          a0_d    = lat_a0_q;
          d_d     = lat_data_q;
        end
      end
      S_SETUP: begin
        if (tick_q) begin
          state_d = S_STROBE;
          wr_n_d  = 1'b0;
          stb_d   = '0;
        end
      end
      S_STROBE: begin
        if (tick_q) begin
          if (stb_q == STB_LAST) begin
            state_d = S_HOLD;
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
          end else begin
            stb_d = stb_q + STB_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (tick_q) begin
          state_d = S_IDLE;
          d_d     = 8'h00;
          guard_d = lat_a0_q ? GUARD_DAT : GUARD_ADR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_XIN_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      tick_q     <= 1'b0;
      guard_q    <= '0;
      stb_q      <= '0;
      lat_a0_q   <= 1'b0;
      lat_data_q <= 8'h00;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      a0_q       <= 1'b0;
      d_q        <= 8'h00;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      guard_q    <= guard_d;
      stb_q      <= stb_d;
      lat_a0_q   <= lat_a0_d;
      lat_data_q <= lat_data_d;
      cs_n_q     <= cs_n_d;
      wr_n_q     <= wr_n_d;
      a0_q       <= a0_d;
      d_q        <= d_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.guard_active = (guard_q != '0);
  assign bus.phim_tick    = tick_q;
  assign bus.cs_n         = cs_n_q;
  assign bus.wr_n         = wr_n_q;
  assign bus.a0           = a0_q;
  assign bus.d            = d_q;

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Self-checking bench for ikaopll_bus_writer: directed scenarios plus random writes
// checked against an edge-count timing model of the write sequence.
module tb_ikaopll_bus_writer;

  localparam int DIV = 4;
  localparam int WR  = 2;
  localparam int GA  = 12;
  localparam int GD  = 84;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errs = 0;
  int   edge_cnt = 0;
  int   cap_count = 0;
  int   m_exit = -1000000;
  int   m_guard = 0;

  ikaopll_bus_writer_if bus ();

  ikaopll_bus_writer #(
    .PHIM_DIV(DIV), .WR_TICKS(WR), .MIN_WAIT_ADDR(GA), .MIN_WAIT_DATA(GD)
  ) dut (
    .i_XIN_EMUCLK(clk),
    .i_IC_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // edge_cnt = index of the last rising edge since reset release (first edge is 1)
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  always @(posedge clk)
    if (rst_n && bus.req_valid === 1'b1 && bus.req_ready === 1'b1) cap_count <= cap_count + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Model: a write starts on the first tick edge after capture, but no earlier than
  // guard ticks after the previous write's exit; it then takes 2+WR ticks to exit.
  function automatic int model_setup(input int cap);
    int s;
    s = (cap / DIV + 1) * DIV;
    if (m_exit + m_guard * DIV > s) s = m_exit + m_guard * DIV;
    return s;
  endfunction

  task automatic model_commit(input int setup, input logic a0);
    m_exit  = setup + (2 + WR) * DIV;
    m_guard = a0 ? GD : GA;
  endtask

  task automatic model_reset();
    m_exit  = -1000000;
    m_guard = 0;
  endtask

  task automatic issue(input logic a0, input logic [7:0] data, output int cap_e, output bit tmo);
    @(negedge clk);
    bus.req_a0    = a0;
    bus.req_data  = data;
    bus.req_valid = 1'b1;
    tmo   = 1'b1;
    cap_e = -1;
    for (int n = 0; n < 2000; n++) begin
      if (bus.req_ready === 1'b1) begin
        @(posedge clk);
        #1;
        cap_e = edge_cnt;
        tmo   = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic observe(output int setup_e, output int cs_low, output int wr_low, output int wr_first,
                         output logic oa0, output logic [7:0] od, output bit stable,
                         output int exit_e, output logic [7:0] d_exit, output logic g_exit, output bit tmo);
    bit seen;
    seen = 0; setup_e = -1; cs_low = 0; wr_low = 0; wr_first = -1; oa0 = 1'b0; od = 8'h00;
    stable = 1; exit_e = -1; d_exit = 8'hxx; g_exit = 1'bx; tmo = 1;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      if (bus.cs_n === 1'b0) begin
        if (!seen) begin
          seen = 1; setup_e = edge_cnt; oa0 = bus.a0; od = bus.d;
        end
        cs_low++;
      end
      if (bus.wr_n === 1'b0) begin
        wr_low++;
        if (wr_first < 0) wr_first = edge_cnt;
      end
      if (seen && bus.req_ready === 1'b1) begin
        exit_e = edge_cnt; d_exit = bus.d; g_exit = bus.guard_active; tmo = 0;
        break;
      end
      if (seen && (bus.a0 !== oa0 || bus.d !== od)) stable = 0;
    end
  endtask

  task automatic test_reset();
    int bad;
    logic exp_t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.cs_n, bus.wr_n, bus.a0, bus.d, bus.req_ready, bus.busy, bus.guard_active, bus.phim_tick}
        !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errs++;
      $display("[TB] FAIL reset_outputs: got cs=%b wr=%b a0=%b d=%h rdy=%b busy=%b grd=%b tick=%b, required 1 1 0 00 1 0 0 0",
               bus.cs_n, bus.wr_n, bus.a0, bus.d, bus.req_ready, bus.busy, bus.guard_active, bus.phim_tick);
    end
    rst_n = 1'b1;
    model_reset();
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      exp_t = ((edge_cnt + 1) % DIV) == 0;
      if (bus.phim_tick !== exp_t) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errs++;
      $display("[TB] FAIL phim_tick_pattern: got %0d wrong samples, required 0", bad);
    end
  endtask

  task automatic test_addr_write();
    int cap, exp, s, csl, wrl, wrf, ex; logic oa0, gx; logic [7:0] od, dx; bit st, tmo;
    issue(1'b0, 8'h10, cap, tmo);
    bus.req_valid = 1'b0;
    exp = model_setup(cap);
    observe(s, csl, wrl, wrf, oa0, od, st, ex, dx, gx, tmo);
    model_commit(exp, 1'b0);
    vectors++; if (tmo !== 1'b0) begin errs++; $display("[TB] FAIL addr_timeout: got timeout, required completion"); end
    vectors++; if (s !== exp) begin errs++; $display("[TB] FAIL addr_setup_edge: got %0d required %0d", s, exp); end
    vectors++; if (csl !== (1 + WR) * DIV) begin errs++; $display("[TB] FAIL addr_cs_low: got %0d required %0d", csl, (1 + WR) * DIV); end
    vectors++; if (wrl !== WR * DIV) begin errs++; $display("[TB] FAIL addr_wr_low: got %0d required %0d", wrl, WR * DIV); end
    vectors++; if (wrf !== exp + DIV) begin errs++; $display("[TB] FAIL addr_wr_start: got %0d required %0d", wrf, exp + DIV); end
    vectors++; if ({oa0, od} !== {1'b0, 8'h10}) begin errs++; $display("[TB] FAIL addr_bus_value: got a0=%b d=%h required a0=0 d=10", oa0, od); end
    vectors++; if (st !== 1'b1) begin errs++; $display("[TB] FAIL addr_stable: got unstable a0/d, required stable"); end
    vectors++; if (ex !== exp + (2 + WR) * DIV) begin errs++; $display("[TB] FAIL addr_ready_return: got %0d required %0d", ex, exp + (2 + WR) * DIV); end
    vectors++; if ({dx, gx} !== {8'h00, 1'b1}) begin errs++; $display("[TB] FAIL addr_exit_state: got d=%h guard=%b required d=00 guard=1", dx, gx); end
  endtask

  task automatic test_back_to_back(input logic first_a0, input logic [7:0] first_d,
                                   input logic second_a0, input logic [7:0] second_d, input int gap_ticks);
    int cap1, cap2, e1, e2, s1, s2, csl, wrl, wrf, ex1, ex2; logic oa0, gx; logic [7:0] od, dx; bit st, tmo1, tmo2, tmo3, tmo4;
    issue(first_a0, first_d, cap1, tmo1);
    bus.req_a0   = second_a0;
    bus.req_data = second_d;
    e1 = model_setup(cap1);
    observe(s1, csl, wrl, wrf, oa0, od, st, ex1, dx, gx, tmo2);
    model_commit(e1, first_a0);
    issue(second_a0, second_d, cap2, tmo3);
    bus.req_valid = 1'b0;
    e2 = model_setup(cap2);
    observe(s2, csl, wrl, wrf, oa0, od, st, ex2, dx, gx, tmo4);
    model_commit(e2, second_a0);
    vectors++; if ({tmo1, tmo2, tmo3, tmo4} !== 4'b0000) begin errs++; $display("[TB] FAIL b2b_timeout: got %b required 0000", {tmo1, tmo2, tmo3, tmo4}); end
    vectors++; if (cap2 !== ex1 + 1) begin errs++; $display("[TB] FAIL b2b_capture: got edge %0d required %0d", cap2, ex1 + 1); end
    vectors++; if (s2 - ex1 !== gap_ticks * DIV) begin errs++; $display("[TB] FAIL b2b_gap: got %0d edges required %0d", s2 - ex1, gap_ticks * DIV); end
    vectors++; if (s2 !== e2) begin errs++; $display("[TB] FAIL b2b_model_setup: got %0d required %0d", s2, e2); end
    vectors++; if ({oa0, od} !== {second_a0, second_d}) begin errs++; $display("[TB] FAIL b2b_bus_value: got a0=%b d=%h required a0=%b d=%h", oa0, od, second_a0, second_d); end
    vectors++; if (wrl !== WR * DIV) begin errs++; $display("[TB] FAIL b2b_wr_low: got %0d required %0d", wrl, WR * DIV); end
  endtask

  task automatic test_reset_mid_strobe();
    int cap, exp, s, csl, wrl, wrf, ex; logic oa0, gx; logic [7:0] od, dx; bit st, tmo, tmo2, found;
    issue(1'b1, 8'h5A, cap, tmo);
    bus.req_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      if (bus.wr_n === 1'b0) begin found = 1; break; end
    end
    vectors++; if ({tmo, found} !== 2'b01) begin errs++; $display("[TB] FAIL rst_strobe_reach: got tmo=%b found=%b required 0 1", tmo, found); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.cs_n, bus.wr_n, bus.d, bus.req_ready, bus.busy, bus.guard_active} !== {1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errs++;
      $display("[TB] FAIL rst_abort: got cs=%b wr=%b d=%h rdy=%b busy=%b grd=%b required 1 1 00 1 0 0",
               bus.cs_n, bus.wr_n, bus.d, bus.req_ready, bus.busy, bus.guard_active);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    issue(1'b0, 8'h22, cap, tmo);
    bus.req_valid = 1'b0;
    exp = model_setup(cap);
    observe(s, csl, wrl, wrf, oa0, od, st, ex, dx, gx, tmo2);
    model_commit(exp, 1'b0);
    vectors++; if ({tmo, tmo2} !== 2'b00) begin errs++; $display("[TB] FAIL rst_after_timeout: got %b required 00", {tmo, tmo2}); end
    vectors++; if (s !== (cap / DIV + 1) * DIV) begin errs++; $display("[TB] FAIL rst_no_guard: got setup %0d required %0d", s, (cap / DIV + 1) * DIV); end
    vectors++; if (wrf !== s + DIV || wrl !== WR * DIV) begin errs++; $display("[TB] FAIL rst_single_strobe: got start %0d len %0d required %0d %0d", wrf, wrl, s + DIV, WR * DIV); end
    vectors++; if (od !== 8'h22) begin errs++; $display("[TB] FAIL rst_after_data: got %h required 22", od); end
  endtask

  task automatic test_busy_data_change();
    int cap, exp, s, csl, wrl, wrf, ex, c0, c1; logic oa0, gx; logic [7:0] od, dx; bit st, tmo, tmo2;
    issue(1'b0, 8'h55, cap, tmo);
    bus.req_data = 8'hAA;
    c0 = cap_count;
    exp = model_setup(cap);
    observe(s, csl, wrl, wrf, oa0, od, st, ex, dx, gx, tmo2);
    c1 = cap_count;
    model_commit(exp, 1'b0);
    vectors++; if ({tmo, tmo2} !== 2'b00) begin errs++; $display("[TB] FAIL busy_timeout: got %b required 00", {tmo, tmo2}); end
    vectors++; if (od !== 8'h55 || st !== 1'b1) begin errs++; $display("[TB] FAIL busy_data: got d=%h stable=%b required 55 1", od, st); end
    vectors++; if (c1 - c0 !== 0) begin errs++; $display("[TB] FAIL busy_single_capture: got %0d extra captures required 0", c1 - c0); end
    issue(1'b0, 8'hAA, cap, tmo);
    bus.req_valid = 1'b0;
    exp = model_setup(cap);
    observe(s, csl, wrl, wrf, oa0, od, st, ex, dx, gx, tmo2);
    model_commit(exp, 1'b0);
    vectors++; if (od !== 8'hAA || s !== exp) begin errs++; $display("[TB] FAIL busy_second: got d=%h setup=%0d required AA %0d", od, s, exp); end
  endtask

  task automatic test_guard_expired();
    int cap, exp, s, csl, wrl, wrf, ex; logic oa0, gx; logic [7:0] od, dx; bit st, tmo, tmo2;
    issue(1'b1, 8'h3C, cap, tmo);
    bus.req_valid = 1'b0;
    exp = model_setup(cap);
    observe(s, csl, wrl, wrf, oa0, od, st, ex, dx, gx, tmo2);
    model_commit(exp, 1'b1);
    repeat (100 * DIV) @(posedge clk);
    #1;
    vectors++; if (bus.guard_active !== 1'b0) begin errs++; $display("[TB] FAIL idle_guard: got %b required 0", bus.guard_active); end
    issue(1'b0, 8'h0E, cap, tmo);
    bus.req_valid = 1'b0;
    exp = model_setup(cap);
    observe(s, csl, wrl, wrf, oa0, od, st, ex, dx, gx, tmo2);
    model_commit(exp, 1'b0);
    vectors++; if (s !== (cap / DIV + 1) * DIV || s - cap < 1 || s - cap > DIV) begin errs++; $display("[TB] FAIL idle_first_tick: got setup %0d (cap %0d) required %0d", s, cap, (cap / DIV + 1) * DIV); end
  endtask

  task automatic test_random();
    int cap, exp, s, csl, wrl, wrf, ex; logic oa0, gx, ra0; logic [7:0] od, dx, rd; bit st, tmo, tmo2;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      ra0 = 1'($urandom_range(0, 1));
      rd  = 8'($urandom);
      issue(ra0, rd, cap, tmo);
      bus.req_valid = 1'b0;
      exp = model_setup(cap);
      observe(s, csl, wrl, wrf, oa0, od, st, ex, dx, gx, tmo2);
      model_commit(exp, ra0);
      vectors++;
      if ({tmo, tmo2} !== 2'b00 || s !== exp || ex !== exp + (2 + WR) * DIV) begin
        errs++;
        $display("[TB] FAIL rand_timing[%0d]: got setup=%0d exit=%0d tmo=%b%b required setup=%0d exit=%0d", i, s, ex, tmo, tmo2, exp, exp + (2 + WR) * DIV);
      end
      vectors++;
      if ({oa0, od, st} !== {ra0, rd, 1'b1} || csl !== (1 + WR) * DIV || wrl !== WR * DIV) begin
        errs++;
        $display("[TB] FAIL rand_bus[%0d]: got a0=%b d=%h st=%b cs=%0d wr=%0d required a0=%b d=%h st=1 cs=%0d wr=%0d",
                 i, oa0, od, st, csl, wrl, ra0, rd, (1 + WR) * DIV, WR * DIV);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a0    = 1'b0;
    bus.req_data  = 8'h00;
    test_reset();
    test_addr_write();
    test_back_to_back(1'b0, 8'h30, 1'b1, 8'h17, GA);
    test_back_to_back(1'b1, 8'h17, 1'b0, 8'h20, GD);
    test_reset_mid_strobe();
    test_busy_data_change();
    test_guard_expired();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
